// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver state encoding,
// the frame data width and the default baud divisor.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_KBAUD_DEF = 10416;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Brings the asynchronous serial line into the clk domain and detects its
// falling edge.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (all flops reset to 1 = idle line)
//   data_i  : raw serial line, asynchronous to clk
//   line_o  : synchronised line level
//   fall_o  : high for one cycle when line_o goes from 1 to 0
// -----------------------------------------------------------------------------
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;   // first stage, may go metastable
  logic line_q;   // second stage, safe to use
  logic prev_q;   // previous value of line_q

  // Resetting to 1 makes the flops look like an idle line, so releasing reset
  // can never fake a start-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true 3-stage shift chain;
      // blocking ones would collapse it into a single flop.
      meta_q <= data_i;
      line_q <= meta_q;
      prev_q <= line_q;
    end
  end

  assign line_o = line_q;
  assign fall_o = prev_q & ~line_q;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, KBAUD clocks per bit. Recovers each byte,
// strobes it out for one cycle and flags frames whose stop bit reads 0.
//   clk           : system clock, single domain
//   rst_n         : asynchronous active-low reset
//   in_DataBit    : serial line (asynchronous, idles high)
//   out_DataByte  : last correctly received byte, held until the next good one
//   out_fValid    : one-cycle pulse when out_DataByte updates
//   out_fFrameErr : set on a 0 stop bit, cleared by the next good frame
//   out_fBusy     : high while a frame is being received
// Build option:
//   UART_RX_MAJORITY_EN : each sample point takes the 2-of-3 majority of the
//                         line at counter = 2, 1, 0 (needs KBAUD >= 8).
//                         Undefined: single sample at counter = 0.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int KBAUD = UART_KBAUD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_DataBit,
  output logic [7:0] out_DataByte,
  output logic       out_fValid,
  output logic       out_fFrameErr,
  output logic       out_fBusy
);

  localparam int CW = $clog2(KBAUD);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF      = CW'(KBAUD / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(KBAUD - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_BITS - 1);

  if (KBAUD < 4) begin : g_kbaud_chk
    $error("uart_rx: KBAUD must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic line;
  logic fall;
  logic samp;   // value used at a sample point

  uart_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (in_DataBit),
    .line_o (line),
    .fall_o (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  if (KBAUD < 8) begin : g_major_chk
    $error("uart_rx: UART_RX_MAJORITY_EN needs KBAUD of at least 8");
  end

  // Two stored samples plus the current one form the three-sample window:
  // hist_q[1] is the line at counter = 2, hist_q[0] at counter = 1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], line};
  end

  assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
  assign samp = line;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bitcnt_q, bitcnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;

  logic sample_pt;
  assign sample_pt = (cnt_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before the case; a path that forgot
    // to assign one would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = ferr_q;

    unique case (state_q)
      S_IDLE: begin
        // Only an edge starts a frame, so a line stuck low stays ignored.
        if (fall) begin
          cnt_d   = HALF;
          state_d = S_START;
        end
      end

      S_START: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!samp) begin
          cnt_d    = BIT_LAST;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else begin
          state_d = S_IDLE;   // glitch, not a start bit
        end
      end

      S_DATA: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d  = {samp, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d    = BIT_LAST;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == DATA_LAST) state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (!sample_pt) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (samp) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ferr_d  = 1'b0;
          end else begin
            ferr_d = 1'b1;
          end
          // Leaving at mid-stop-bit lets an immediately following start bit
          // be caught.
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      // NOTE: the shift register is reset as well; it is a handful of flops,
      // not a memory array, and a known value keeps simulation X-free.
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign out_DataByte  = data_q;
  assign out_fValid    = valid_q;
  assign out_fFrameErr = ferr_q;
  assign out_fBusy     = (state_q != S_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at KBAUD = 16. The transmitter is modelled
// as a task that serialises {stop, byte, start}; expected results come from
// the frame contents alone (good stop bit -> byte delivered, else error flag).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int KBAUD   = 16;
  localparam int LAT     = 3 + (KBAUD / 2 - 1) + 1 + 9 * KBAUD;
  localparam int CLK_PER = 10;

  logic       clk;
  logic       rst_n;
  logic       in_DataBit;
  logic [7:0] out_DataByte;
  logic       out_fValid;
  logic       out_fFrameErr;
  logic       out_fBusy;

  int total = 0;
  int bad   = 0;

  int unsigned cycle_cnt = 0;
  bit          glitch_en = 1'b0;

  // Observed valid strobes
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  logic        prev_valid = 1'b0;
  bit          dbl_valid  = 1'b0;

  logic [7:0] last_good;   // model of out_DataByte

  uart_rx #(.KBAUD(KBAUD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_DataBit    (in_DataBit),
    .out_DataByte  (out_DataByte),
    .out_fValid    (out_fValid),
    .out_fFrameErr (out_fFrameErr),
    .out_fBusy     (out_fBusy)
  );

  initial clk = 1'b0;
  always #(CLK_PER / 2) clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (out_fValid) begin
      got_q.push_back(out_DataByte);
      got_t.push_back(cycle_cnt);
      if (prev_valid) dbl_valid = 1'b1;
    end
    prev_valid = out_fValid;
  end

  initial begin
    #(2_000_000 * CLK_PER);
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all leave time at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    in_DataBit = b;
    for (int i = 0; i < KBAUD; i++) begin
      if (glitch_en && i == KBAUD / 2)          in_DataBit = ~b;
      else if (glitch_en && i == KBAUD / 2 + 1) in_DataBit = b;
      step(1);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    in_DataBit = 1'b1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n      = 1'b0;
    in_DataBit = 1'b1;
    step(3);
    total++; if (out_DataByte !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_DataByte); end
    total++; if (out_fValid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b want 0", out_fValid); end
    total++; if (out_fFrameErr !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", out_fFrameErr); end
    total++; if (out_fBusy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", out_fBusy); end
    rst_n = 1'b1;
    step(5);
    last_good = 8'h00;
    clear_obs();
  endtask

  task automatic test_single();
    int unsigned t0;
    int          lat;
    t0 = cycle_cnt;
    drive_frame(8'hA5, 1'b1);
    step(4);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL single_count: got %0d pulses want 1", got_q.size());
    end else begin
      lat = int'(got_t[0] - t0);
      total++; if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", got_q[0]); end
      total++; if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT); end
    end
    total++; if (out_fFrameErr !== 1'b0) begin bad++; $display("FAIL single_ferr: got %b want 0", out_fFrameErr); end
    last_good = 8'hA5;
    clear_obs();
  endtask

  task automatic test_back_to_back();
    drive_frame(8'h00, 1'b1);
    drive_frame(8'hFF, 1'b1);
    step(4);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d pulses want 2", got_q.size());
    end else begin
      total++; if (got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", got_q[0]); end
      total++; if (got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", got_q[1]); end
    end
    last_good = 8'hFF;
    clear_obs();
  endtask

  task automatic test_glitch();
    bit rose = 1'b0;
    int dur  = 0;
    in_DataBit = 1'b0;
    step(3);
    in_DataBit = 1'b1;
    for (int i = 0; i < 10 && !rose; i++) begin
      if (out_fBusy) rose = 1'b1;
      else step(1);
    end
    total++; if (!rose) begin bad++; $display("FAIL glitch_busy_rise: got 0 want 1"); end
    while (rose && out_fBusy && dur < 30) begin
      step(1);
      dur++;
    end
    total++; if (dur > 9) begin bad++; $display("FAIL glitch_busy_len: got %0d want <=9", dur); end
    step(KBAUD * 12);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL glitch_valid: got %0d pulses want 0", got_q.size()); end
    total++; if (out_DataByte !== last_good) begin bad++; $display("FAIL glitch_data: got %h want %h", out_DataByte, last_good); end
    clear_obs();
  endtask

  task automatic test_frame_err();
    drive_frame(8'h3C, 1'b0);
    step(4);
    total++; if (out_fFrameErr !== 1'b1) begin bad++; $display("FAIL ferr_set: got %b want 1", out_fFrameErr); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL ferr_valid: got %0d pulses want 0", got_q.size()); end
    total++; if (out_DataByte !== last_good) begin bad++; $display("FAIL ferr_data_held: got %h want %h", out_DataByte, last_good); end
    clear_obs();
    drive_frame(8'h12, 1'b1);
    step(4);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL ferr_recover_count: got %0d pulses want 1", got_q.size());
    end else begin
      total++; if (got_q[0] !== 8'h12) begin bad++; $display("FAIL ferr_recover_data: got %h want 12", got_q[0]); end
    end
    total++; if (out_fFrameErr !== 1'b0) begin bad++; $display("FAIL ferr_clear: got %b want 0", out_fFrameErr); end
    last_good = 8'h12;
    clear_obs();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    in_DataBit = d[4];   // 1: the line stays high once the frame is abandoned
    step(KBAUD / 2);
    rst_n = 1'b0;
    step(2);
    total++; if (out_fBusy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_in_reset: got %b want 0", out_fBusy); end
    rst_n = 1'b1;
    in_DataBit = 1'b1;
    step(KBAUD * 4);
    last_good = 8'h00;
    total++; if (got_q.size() != 0)     begin bad++; $display("FAIL rstmid_valid: got %0d pulses want 0", got_q.size()); end
    total++; if (out_DataByte !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", out_DataByte); end
    total++; if (out_fFrameErr !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b want 0", out_fFrameErr); end
    total++; if (out_fBusy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy: got %b want 0", out_fBusy); end
    clear_obs();
    drive_frame(8'h81, 1'b1);
    step(4);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL rstmid_next_count: got %0d pulses want 1", got_q.size());
    end else begin
      total++; if (got_q[0] !== 8'h81) begin bad++; $display("FAIL rstmid_next_data: got %h want 81", got_q[0]); end
    end
    last_good = 8'h81;
    clear_obs();
  endtask

  task automatic test_loopback();
`ifdef UART_RX_MAJORITY_EN
    glitch_en = 1'b1;
`endif
    for (int b = 0; b < 256; b++) begin
      drive_frame(8'(b), 1'b1);
      step(int'($urandom_range(0, 3)));
      total++;
      if (got_q.size() != 1) begin
        bad++; $display("FAIL loop_count[%0d]: got %0d pulses want 1", b, got_q.size());
      end else if (got_q[0] !== 8'(b)) begin
        bad++; $display("FAIL loop_data[%0d]: got %h want %h", b, got_q[0], 8'(b));
      end
      total++; if (out_fFrameErr !== 1'b0) begin bad++; $display("FAIL loop_ferr[%0d]: got %b want 0", b, out_fFrameErr); end
      clear_obs();
    end
    glitch_en = 1'b0;
    last_good = 8'hFF;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      drive_frame(d, stop);
      step(int'($urandom_range(1, 4)));
      if (stop) last_good = d;
      total++;
      if (got_q.size() != (stop ? 1 : 0)) begin
        bad++; $display("FAIL rand_count[%0d]: got %0d pulses want %0d", n, got_q.size(), stop ? 1 : 0);
      end
      total++; if (out_DataByte !== last_good) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, out_DataByte, last_good); end
      total++; if (out_fFrameErr !== ~stop) begin bad++; $display("FAIL rand_ferr[%0d]: got %b want %b", n, out_fFrameErr, ~stop); end
      clear_obs();
    end
  endtask

  task automatic test_no_double_valid();
    total++; if (dbl_valid) begin bad++; $display("FAIL valid_width: got 2+ cycle pulse want 1 cycle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_loopback();
    test_random();
    test_no_double_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; consumes the line driven by UartTx (8N1, LSB first, KBAUD clocks per bit).
- Recovers each byte and presents it with a one-cycle valid strobe to the Wishbone-side register block.
- Flags framing errors.
- Sits directly downstream of UartTx, on the opposite end of the serial link or in loopback.

Parameters:
- KBAUD, 10416: clock cycles per bit. Must be ≥ 4. Must match the transmitter.

Ports:
- clk  input  1  system clock. Single clock domain; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_DataBit  input  1  serial line, asynchronous to clk. Idles high.
- out_DataByte  output  8  last correctly received byte. Held until the next good frame.
- out_fValid  output  1  one-cycle pulse when out_DataByte is updated.
- out_fFrameErr  output  1  set when a stop bit is sampled as 0. Cleared by the next good frame.
- out_fBusy  output  1  high while a frame is in progress, i.e. state ≠ S_IDLE.

Behaviour:
- Reset values:
  - out_DataByte = 0x00, out_fValid = 0, out_fFrameErr = 0, out_fBusy = 0.
  - State = S_IDLE.
  - Synchronizer flops and previous-sample flop = 1.
  - Baud counter = 0, bit counter = 0.
- Input path:
  - 2-flop synchronizer feeds `line`.
  - A third flop holds `line_d`.
  - Falling edge = line_d & ~line.
- Baud counter: down-counter, width $clog2(KBAUD). A sample point occurs when the counter = 0. HALF = KBAUD/2 − 1 (integer division).
- S_IDLE:
  - On a falling edge: load HALF, go to S_START.
  - A line held low (break, or after an error) does not retrigger; only a falling edge starts a frame.
- S_START:
  - Counter ≠ 0: decrement.
  - At the sample point, line = 0: load KBAUD−1, bit counter = 0, go to S_DATA.
  - At the sample point, line = 1: false start (glitch), go to S_IDLE. No outputs change.
- S_DATA:
  - At each sample point: shift register <= {sample, shreg[7:1]} (LSB first), load KBAUD−1, bit counter +1.
  - After the 8th sample (bit counter was 7): go to S_STOP.
- S_STOP:
  - At the sample point, line = 1: out_DataByte <= shreg, out_fValid = 1 for exactly one cycle, out_fFrameErr <= 0.
  - At the sample point, line = 0: out_fFrameErr <= 1; out_fValid stays 0 and out_DataByte is unchanged.
  - Either case: go to S_IDLE.
- Latency:
  - out_fValid rises 3 + HALF + 1 + 9·KBAUD cycles after in_DataBit falls.
  - Bench tolerance is ±1 cycle.
- Back-to-back frames: the receiver returns to S_IDLE at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- Reset mid-frame:
  - Abort immediately and return to reset values.
  - No valid pulse is issued for the partial frame.
  - The next falling edge after deassertion starts a fresh frame.
- out_fValid is never high for two consecutive cycles. There is no backpressure; the consumer must take the byte on the strobe.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-bit history of `line` is kept.
  - Every sample point (start, data, stop) uses the majority of the values at counter = 2, 1 and 0.
  - Requires KBAUD ≥ 8; an elaboration-time error is raised otherwise.
- Undefined: single sample of `line` at counter = 0. The history register is not built.

Decomposition:
- Package uart_pkg:
  - State enum rx_state_t {S_IDLE, S_START, S_DATA, S_STOP}, 2 bits.
  - UART_DATA_BITS = 8.
  - UART_KBAUD_DEF = 10416.
- Sub-module uart_sync:
  - 2-flop synchronizer plus previous-sample flop, async active-low reset to 1.
  - Outputs `line` and `fall`.
- All other logic stays in uart_rx.

Test Plan (KBAUD = 16 for simulation):
- Drive 0xA5 as 8N1 at 16 clocks/bit → one out_fValid pulse 3+8+9·16 (±1) cycles after the start edge; out_DataByte = 0xA5; out_fFrameErr = 0.
- Drive 0x00 then 0xFF back-to-back (next start bit directly after the stop bit) → two valid pulses, data 0x00 then 0xFF.
- Low glitch of 3 clocks on an idle line → no valid pulse; out_fBusy drops within 9 cycles; out_DataByte unchanged.
- Drive 0x3C with the stop bit forced to 0 → out_fFrameErr = 1, no valid pulse. Then a good 0x12 → valid pulse, data 0x12, out_fFrameErr = 0.
- Assert rst_n low during data bit 4 of 0x55 for 2 cycles → no valid pulse; all outputs at reset values. A following 0x81 is received correctly.
- Loopback to UartTx (KBAUD = 16), sending 0x00..0xFF → 256 valid pulses, each byte matches, no framing errors.
  - With UART_RX_MAJORITY_EN defined: additionally inject 1-cycle inverted glitches at each mid-bit → all bytes still match.
